// File: rtl/s_dadda_arb2_pkg.sv
// Shared types and helpers for the two-requester Dadda multiplier arbiter.
package s_dadda_arb2_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } op_pair_t;

    // {carry, sum}
    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

endpackage

// File: rtl/s_dadda_rca4.sv
// 4x4 signed multiplier: Baugh-Wooley partial products, Dadda reduction
// to two rows, ripple-carry final adder.
module s_dadda_rca4
    import s_dadda_arb2_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] prod
);

    logic [OP_W-1:0][OP_W-1:0] pp;

    // Terms pairing exactly one sign bit are inverted; the matching
    // correction constants are a 1 in column 4 and a 1 in column 7.
    always_comb begin
        for (int i = 0; i < OP_W; i++) begin
            for (int j = 0; j < OP_W; j++) begin
                pp[i][j] = (a[i] & b[j]) ^ ((i == OP_W-1) != (j == OP_W-1));
            end
        end
    end

    logic s1_3, c1_4, s1_4, c1_5;
    logic s2_2, c2_3, s2_3, c2_4, s2_4, c2_5, s2_5, c2_6;

    // Stage 1: max column height 4 -> 3
    assign {c1_4, s1_3} = ha(pp[3][0], pp[2][1]);
    assign {c1_5, s1_4} = fa(pp[3][1], pp[2][2], pp[1][3]);

    // Stage 2: max column height 3 -> 2
    assign {c2_3, s2_2} = ha(pp[2][0], pp[1][1]);
    assign {c2_4, s2_3} = fa(s1_3, pp[1][2], pp[0][3]);
    assign {c2_5, s2_4} = fa(s1_4, 1'b1, c1_4);
    assign {c2_6, s2_5} = fa(pp[3][2], pp[2][3], c1_5);

    logic [6:0] row_x, row_y;
    logic [7:0] cy;

    assign row_x = {pp[3][3], s2_5, s2_4, s2_3, s2_2, pp[1][0], pp[0][0]};
    assign row_y = {c2_6, c2_5, c2_4, c2_3, pp[0][2], pp[0][1], 1'b0};
    assign cy[0] = 1'b0;

    for (genvar k = 0; k < 7; k++) begin : g_rca
        assign {cy[k+1], prod[k]} = fa(row_x[k], row_y[k], cy[k]);
    end

    // Column-7 correction constant folds into the final carry.
    assign prod[7] = ~cy[7];

endmodule

// File: rtl/s_dadda_arb2.sv
// Round-robin arbiter sharing one 4x4 signed multiplier between two requesters.
// Optional per-requester accept counters under S_DADDA_ARB2_CNT_EN.
module s_dadda_arb2
    import s_dadda_arb2_pkg::*;
#(
    parameter int PRIO_INIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_a,
    input  logic [OP_W-1:0]   req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_a,
    input  logic [OP_W-1:0]   req1_b,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [PROD_W-1:0] resp0_prod,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [PROD_W-1:0] resp1_prod
`ifdef S_DADDA_ARB2_CNT_EN
    ,
    output logic [7:0]        grant_cnt0,
    output logic [7:0]        grant_cnt1
`endif
);

    state_t            state_q;
    op_pair_t          ops_q;
    logic              grant_q;
    logic              prio_q;
    logic [PROD_W-1:0] prod_q;
    logic [1:0]        resp_vld_q;
    logic [PROD_W-1:0] mul_out;

    logic sel, accept, resp_hs;

    always_comb begin
        sel     = (req0_valid && req1_valid) ? prio_q : req1_valid;
        accept  = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
        resp_hs = (state_q == RESP) && (grant_q ? resp1_ready : resp0_ready);
    end

    assign req0_ready  = accept && !sel;
    assign req1_ready  = accept && sel;
    assign resp0_valid = resp_vld_q[0];
    assign resp1_valid = resp_vld_q[1];
    assign resp0_prod  = resp_vld_q[0] ? prod_q : '0;
    assign resp1_prod  = resp_vld_q[1] ? prod_q : '0;

    s_dadda_rca4 u_mul (
        .a    (ops_q.a),
        .b    (ops_q.b),
        .prod (mul_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ops_q      <= '0;
            grant_q    <= 1'b0;
            prio_q     <= 1'(PRIO_INIT);
            prod_q     <= '0;
            resp_vld_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    ops_q   <= sel ? op_pair_t'{req1_a, req1_b} : op_pair_t'{req0_a, req0_b};
                    grant_q <= sel;
                    state_q <= MUL;
                end
                MUL: begin
                    prod_q     <= mul_out;
                    resp_vld_q <= grant_q ? 2'b10 : 2'b01;
                    state_q    <= RESP;
                end
                RESP: if (resp_hs) begin
                    resp_vld_q <= '0;
                    prod_q     <= '0;
                    prio_q     <= ~grant_q;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef S_DADDA_ARB2_CNT_EN
    logic [7:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (accept) begin
            if (sel) cnt1_q <= cnt1_q + 8'd1;
            else     cnt0_q <= cnt0_q + 8'd1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_s_dadda_arb2.sv
// Self-checking bench for s_dadda_arb2 against an arithmetic/round-robin model.
// Define S_DADDA_ARB2_CNT_EN to also exercise the accept counters.
module tb_s_dadda_arb2;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [7:0] resp0_prod, resp1_prod;
`ifdef S_DADDA_ARB2_CNT_EN
    logic [7:0] grant_cnt0, grant_cnt1;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_prio = 0;

    always #5 clk = ~clk;

    s_dadda_arb2 #(.PRIO_INIT(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp0_prod  (resp0_prod),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp1_prod  (resp1_prod)
`ifdef S_DADDA_ARB2_CNT_EN
        ,
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_prod(input logic [3:0] a, input logic [3:0] b);
        int x, y;
        x = $signed(a);
        y = $signed(b);
        return 8'(x * y);
    endfunction

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_rv0"}, resp0_valid, 0);
        chk({tag, "_rv1"}, resp1_valid, 0);
        chk({tag, "_p0"},  resp0_prod, 0);
        chk({tag, "_p1"},  resp1_prod, 0);
    endtask

    task automatic chk_resp(input int g, input logic [7:0] ep);
        chk("rsp_rv0", resp0_valid, g == 0);
        chk("rsp_rv1", resp1_valid, g == 1);
        chk("rsp_p0",  resp0_prod, (g == 0) ? ep : 8'h00);
        chk("rsp_p1",  resp1_prod, (g == 1) ? ep : 8'h00);
        chk("rsp_rdy", {req0_ready, req1_ready}, 0);
    endtask

    // Entered and left at posedge+1. Accepts on the next edge, checks the
    // MUL and RESP phases, holds resp_ready low for `stall` RESP cycles.
    task automatic txn(input logic v0, input logic v1,
                       input logic [3:0] a0, input logic [3:0] b0,
                       input logic [3:0] a1, input logic [3:0] b1,
                       input int stall);
        int g;
        logic [7:0] ep;
        g  = (v0 && v1) ? exp_prio : (v1 ? 1 : 0);
        ep = (g == 1) ? ref_prod(a1, b1) : ref_prod(a0, b0);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        #1;
        chk("acc_rdy0", req0_ready, g == 0);
        chk("acc_rdy1", req1_ready, g == 1);
        @(posedge clk); #1;
        // The losing requester keeps its request up; it must not be accepted.
        if (g == 1) begin
            req1_valid = 1'b0; resp1_ready = (stall == 0); resp0_ready = 1'b1;
        end else begin
            req0_valid = 1'b0; resp0_ready = (stall == 0); resp1_ready = 1'b1;
        end
        #1;
        chk("mul_rdy", {req0_ready, req1_ready}, 0);
        chk_idle_outs("mul");
        @(posedge clk); #1;
        for (int k = 0; k < stall; k++) begin
            chk_resp(g, ep);
            @(posedge clk); #1;
        end
        if (g == 1) resp1_ready = 1'b1; else resp0_ready = 1'b1;
        #1;
        chk_resp(g, ep);
        @(posedge clk); #1;
        chk_idle_outs("done");
        exp_prio = 1 - g;
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_rdy", {req0_ready, req1_ready}, 0);
        chk_idle_outs("rst");
        @(posedge clk); #1;
        chk("rst_rdy_hold", {req0_ready, req1_ready}, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        exp_prio = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        resp0_ready = 0; resp1_ready = 0;
        @(posedge clk); #1;
        do_reset();

        // Single requester, 3 * -2
        txn(1'b1, 1'b0, 4'h3, 4'hE, 4'h0, 4'h0, 0);

        // Contention after reset: expect 0,1,0,1 at the 3-cycle issue interval
        do_reset();
        for (int i = 0; i < 4; i++)
            txn(1'b1, 1'b1, 4'(i + 1), 4'h5, 4'(i + 9), 4'h7, 0);

        // Full operand sweep on req1
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                txn(1'b0, 1'b1, 4'h0, 4'h0, 4'(a), 4'(b), 0);

        // Back-pressure on req0
        txn(1'b1, 1'b0, 4'h8, 4'h7, 4'h0, 4'h0, 5);

        // Randomized traffic with random contention and stalls
        for (int i = 0; i < 60; i++) begin
            logic v0, v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            txn(v0, v1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                int'($urandom_range(0, 3)));
        end

        // Reset while the multiplier stage is busy
        req0_valid = 1'b1; req0_a = 4'h5; req0_b = 4'h3;
        #1;
        chk("mrst_acc", req0_ready, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mrst_rdy", {req0_ready, req1_ready}, 0);
        chk_idle_outs("mrst");
        @(posedge clk); @(posedge clk); #1;
        chk_idle_outs("mrst_hold");
        req0_valid = 1'b0;
        rst = 1'b0;
        exp_prio = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk_idle_outs("mrst_after");
        end
        txn(1'b1, 1'b0, 4'h9, 4'hB, 4'h0, 4'h0, 1);
        txn(1'b1, 1'b1, 4'h6, 4'h6, 4'hC, 4'h3, 0);

`ifdef S_DADDA_ARB2_CNT_EN
        do_reset();
        chk("cnt0_rst", grant_cnt0, 0);
        chk("cnt1_rst", grant_cnt1, 0);
        for (int i = 0; i < 300; i++)
            txn(1'b1, 1'b0, 4'($urandom), 4'($urandom), 4'h0, 4'h0, 0);
        for (int i = 0; i < 5; i++)
            txn(1'b0, 1'b1, 4'h0, 4'h0, 4'($urandom), 4'($urandom), 0);
        chk("cnt0", grant_cnt0, 300 % 256);
        chk("cnt1", grant_cnt1, 5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
